// File: rtl/program_memory_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the program memory and
// program_memory_arbiter. The arbiter uses the slave modport.
interface program_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: a requester raises req with a stable addr and holds both until
  // it sees gnt in the same cycle; the read word comes back with valid exactly
  // one cycle after gnt. req may stay high for back-to-back reads, one per cycle.
  logic                  fetch_req;
  logic [DATA_WIDTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;

  logic                  dbg_req;
  logic [DATA_WIDTH-1:0] dbg_addr;
  logic                  dbg_gnt;
  logic                  dbg_valid;
  logic [DATA_WIDTH-1:0] dbg_data;

  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_instruction;
  logic                  addr_err;

  modport slave (
    input  fetch_req, fetch_addr, dbg_req, dbg_addr, mem_instruction,
    output fetch_gnt, fetch_valid, fetch_data,
    output dbg_gnt, dbg_valid, dbg_data,
    output mem_address, addr_err
  );

  modport master (
    output fetch_req, fetch_addr, dbg_req, dbg_addr, mem_instruction,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  dbg_gnt, dbg_valid, dbg_data,
    input  mem_address, addr_err
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// Fetch-priority arbiter for the shared program memory with a starvation
// guarantee for the debug port. Optional macro PROGRAM_MEMORY_ARBITER_ADDR_CHECK_EN.
module program_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  program_memory_arbiter_if.slave bus,
  output logic [CNT_W-1:0]        starve_cnt
);

  if (STARVE_LIMIT < 1 || MEMORY_DEPTH < 1 || DATA_WIDTH < 3) begin : g_param_check
    $error("program_memory_arbiter: illegal parameter setting");
  end

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] fetch_data_q,  fetch_data_d;
  logic                  dbg_valid_q,   dbg_valid_d;
  logic [DATA_WIDTH-1:0] dbg_data_q,    dbg_data_d;
  logic                  addr_err_q,    addr_err_d;
  logic [CNT_W-1:0]      starve_cnt_q,  starve_cnt_d;

  logic                  starve_full;
  logic                  fetch_win;
  logic                  dbg_win;
  logic [DATA_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  assign starve_full = (starve_cnt_q == LIMIT_C);

  // Debug wins when alone or once fetch has used up its allowance of grants.
  always_comb begin
    dbg_win    = bus.dbg_req && (!bus.fetch_req || starve_full);
    fetch_win  = bus.fetch_req && !dbg_win;
    grant_addr = dbg_win ? bus.dbg_addr : bus.fetch_addr;
  end

`ifdef PROGRAM_MEMORY_ARBITER_ADDR_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] DEPTH_C = DATA_WIDTH'(MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] word_idx;
  logic                  addr_bad;

  // Out-of-range or misaligned reads return a NOP instead of memory contents.
  always_comb begin
    word_idx = {2'b00, grant_addr[DATA_WIDTH-1:2]};
    addr_bad = (word_idx >= DEPTH_C) || (grant_addr[1:0] != 2'b00);
    rd_data  = addr_bad ? '0 : bus.mem_instruction;
    rd_err   = addr_bad;
  end
`else
  always_comb begin
    rd_data = bus.mem_instruction;
    rd_err  = 1'b0;
  end
`endif

  always_comb begin
    fetch_valid_d = fetch_win;
    fetch_data_d  = fetch_data_q;
    dbg_valid_d   = dbg_win;
    dbg_data_d    = dbg_data_q;
    addr_err_d    = (fetch_win || dbg_win) && rd_err;
    starve_cnt_d  = starve_cnt_q;

    if (fetch_win) begin
      fetch_data_d = rd_data;
    end
    if (dbg_win) begin
      dbg_data_d = rd_data;
    end

    // Count only fetch grants that overtook a waiting debug request.
    if (dbg_win || !bus.dbg_req) begin
      starve_cnt_d = '0;
    end else if (fetch_win && !starve_full) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      dbg_valid_q   <= 1'b0;
      dbg_data_q    <= '0;
      addr_err_q    <= 1'b0;
      starve_cnt_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      dbg_valid_q   <= dbg_valid_d;
      dbg_data_q    <= dbg_data_d;
      addr_err_q    <= addr_err_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

  assign bus.fetch_gnt   = fetch_win;
  assign bus.dbg_gnt     = dbg_win;
  assign bus.mem_address = grant_addr;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.dbg_valid   = dbg_valid_q;
  assign bus.dbg_data    = dbg_data_q;
  assign bus.addr_err    = addr_err_q;
  assign starve_cnt      = starve_cnt_q;

endmodule

// File: doc/program_memory_arbiter.md
# program_memory_arbiter

Shares the single combinational-read program memory between the instruction-fetch path and a debug/loader read port. Fetch has priority. A starvation counter guarantees the debug port a slot after a bounded number of back-to-back fetch grants. Each granted read returns the instruction word registered, one cycle after the grant. The block sits between the PC/fetch logic and the program memory in the single-cycle MIPS top level.

## Interface
- DATA_WIDTH, 32, address and instruction width
- MEMORY_DEPTH, 32, program memory depth in words (used only by the address check)
- STARVE_LIMIT, 4, maximum consecutive fetch grants while a debug request waits (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- fetch_req  input  1  fetch read request
- fetch_addr  input  DATA_WIDTH  fetch byte address
- fetch_gnt  output  1  fetch request granted this cycle (combinational)
- fetch_valid  output  1  fetch_data valid (registered)
- fetch_data  output  DATA_WIDTH  instruction returned to fetch
- dbg_req  input  1  debug read request
- dbg_addr  input  DATA_WIDTH  debug byte address
- dbg_gnt  output  1  debug request granted this cycle (combinational)
- dbg_valid  output  1  dbg_data valid (registered)
- dbg_data  output  DATA_WIDTH  instruction returned to debug
- mem_address  output  DATA_WIDTH  byte address driven to program memory
- mem_instruction  input  DATA_WIDTH  instruction read from program memory
- addr_err  output  1  registered out-of-range flag (only with the macro)

## Operation
- Grant is decided combinationally each cycle from the requests and starve_cnt (0..STARVE_LIMIT).
  - dbg_req only: grant debug.
  - fetch_req only: grant fetch.
  - Both requests, starve_cnt < STARVE_LIMIT: grant fetch.
  - Both requests, starve_cnt == STARVE_LIMIT: grant debug.
  - No request: no grant. mem_address = fetch_addr.
- mem_address = the granted requester's address. fetch_gnt and dbg_gnt are never high together.
- Response register at the clock edge ending a grant cycle:
  - Granted side: data ← mem_instruction, valid ← 1.
  - Other side: valid ← 0, data holds its previous value.
- starve_cnt update at each clock edge:
  - Increments when fetch is granted while dbg_req is high.
  - Clears when debug is granted or dbg_req is low.
  - Saturates at STARVE_LIMIT.
- Handshake: a requester holds req and addr stable until it sees gnt. It may deassert req in the cycle after gnt, or keep it high for back-to-back reads.
- Byte addresses pass through unchanged. Program memory drops bits [1:0].

## Timing
- Reset (asynchronous, while reset==0): fetch_valid=0, dbg_valid=0, fetch_data=0, dbg_data=0, starve_cnt=0, addr_err=0.
- gnt is high in the same cycle as req (cycle N). valid and data are high in cycle N+1. Latency is 1 cycle, throughput is 1 read per cycle.
- Continuous fetch_req with dbg_req raised in cycle N and held:
  - Fetch is granted for STARVE_LIMIT cycles (N..N+STARVE_LIMIT-1).
  - Debug is granted in cycle N+STARVE_LIMIT.
  - Fetch is granted again in the following cycle.
- Reset asserted mid-transaction: a pending valid is dropped and no response is produced for that grant. Requests present at reset release are arbitrated normally in the first clocked cycle.
- If dbg_req drops while waiting, starve_cnt clears at the next edge.

## Configuration
- Macro PROGRAM_MEMORY_ARBITER_ADDR_CHECK_EN.
- Defined:
  - A granted address with (addr>>2) ≥ MEMORY_DEPTH, or addr[1:0]≠0, returns data 32'h0000_0000 (NOP) with valid=1.
  - addr_err pulses high in the response cycle.
  - mem_address is still driven.
- Undefined: mem_instruction is always passed through, and addr_err is tied to 0.

## Test plan
- Reset: hold reset=0 with both requests high → all valids 0, all data 0. Release reset → fetch granted in the first cycle.
- Fetch only: fetch_addr=0x4, memory word1=0x2008000A → fetch_gnt in cycle N, fetch_valid=1 and fetch_data=0x2008000A in N+1.
- Contention with STARVE_LIMIT=4: fetch_req continuous and dbg_req from cycle 0 → fetch_gnt in cycles 0-3, dbg_gnt in cycle 4, dbg_valid in cycle 5, fetch_gnt resumes in cycle 5.
- Debug only, back-to-back: dbg_addr=0x0, 0x4, 0x8 on consecutive cycles → dbg_valid high for 3 cycles, returning words 0, 1, 2 in order.
- Reset mid-read: assert reset in the grant cycle → no valid in the next cycle, starve_cnt=0.
- Macro defined: fetch_addr=0x80 (word 32, MEMORY_DEPTH=32) → fetch_data=0, addr_err=1 for one cycle. fetch_addr=0x2 → same result.
